// File: rtl/core.sv
// Shared core package: assemble-stage bundles, states and load funct3 codes.
// Forwarding bundle fwd_t is consumed only when ASM_STAGE_FWD_EN is defined.
package core;

    localparam int XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        OUT_HOLD
    } asm_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       has_rd;
        logic       is_load;
        logic [2:0] funct3;
    } de_inst_t;

    typedef struct packed {
        logic            valid;
        de_inst_t        de_inst;
        logic [XLEN-1:0] ex_result;
    } ex_asm_t;

    typedef struct packed {
        logic            valid;
        de_inst_t        de_inst;
        logic [XLEN-1:0] asm_result;
    } asm_wb_t;

    typedef struct packed {
        logic            en;
        logic [XLEN-1:0] addr;
    } mem_read_req_t;

    typedef struct packed {
        logic            done;
        logic [XLEN-1:0] data;
    } mem_read_rsp_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } fwd_t;

endpackage

// File: rtl/asm_stage_if.sv
// Data-memory read bus between the assemble stage and data memory.
// master issues requests, slave returns done/data.
interface asm_stage_if;
    import core::*;

    mem_read_req_t mem_read_req;
    mem_read_rsp_t mem_read_rsp;

    modport master (
        output mem_read_req,
        input  mem_read_rsp
    );

    modport slave (
        input  mem_read_req,
        output mem_read_rsp
    );

endinterface

// File: rtl/load_extract.sv
// Combinational load data extraction: selects byte/half by offset and
// sign- or zero-extends according to funct3.
module load_extract
    import core::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    // Misaligned halves/words simply drop the low offset bits.
    always_comb begin
        case (funct3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result = {24'd0, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LHU:     result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/asm_stage.sv
// Assemble stage: completes loads over the memory read bus and registers
// the writeback bundle. Define ASM_STAGE_FWD_EN to add the fwd bypass port.
module asm_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  core::ex_asm_t ex_asm,
    input  logic          wb_rdy,
    asm_stage_if.master   mem,
    output core::asm_wb_t asm_wb,
    output logic          rdy
`ifdef ASM_STAGE_FWD_EN
    ,
    output core::fwd_t    fwd
`endif
);

    import core::*;

    asm_state_e      state_q, state_d;
    de_inst_t        inst_q, inst_d;
    logic [XLEN-1:0] addr_q, addr_d;
    asm_wb_t         wb_q, wb_d;
    logic [XLEN-1:0] ld_data;
    logic            accept;

    load_extract u_extract (
        .word   (mem.mem_read_rsp.data),
        .off    (addr_q[1:0]),
        .funct3 (inst_q.funct3),
        .result (ld_data)
    );

    always_comb begin
        rdy = en && !rst
            && (state_q == IDLE
                || (state_q == OUT_HOLD && wb_rdy));
        accept = rdy && ex_asm.valid;

        state_d = state_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        wb_d    = wb_q;

        case (state_q)
            MEM_WAIT: begin
                if (mem.mem_read_rsp.done) begin
                    wb_d.valid      = 1'b1;
                    wb_d.de_inst    = inst_q;
                    wb_d.asm_result = ld_data;
                    state_d         = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                if (wb_rdy) begin
                    wb_d.valid = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: ;
        endcase

        // Accept overrides the retire above for back-to-back flow.
        if (accept) begin
            if (ex_asm.de_inst.is_load) begin
                inst_d     = ex_asm.de_inst;
                addr_d     = ex_asm.ex_result;
                wb_d.valid = 1'b0;
                state_d    = MEM_WAIT;
            end else begin
                wb_d.valid      = 1'b1;
                wb_d.de_inst    = ex_asm.de_inst;
                wb_d.asm_result = ex_asm.ex_result;
                state_d         = OUT_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            inst_q  <= '0;
            addr_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
        end
    end

    assign mem.mem_read_req.en   = !rst && (state_q == MEM_WAIT);
    assign mem.mem_read_req.addr = {addr_q[XLEN-1:2], 2'b00};
    assign asm_wb                = wb_q;

`ifdef ASM_STAGE_FWD_EN
    assign fwd.valid = wb_q.valid && wb_q.de_inst.has_rd
                     && (wb_q.de_inst.rd != 5'd0);
    assign fwd.rd    = wb_q.de_inst.rd;
    assign fwd.data  = wb_q.asm_result;
`endif

endmodule

// File: tb/tb_asm_stage.sv
// Randomized and directed bench for asm_stage against a transaction-level
// model of held result, pending load and byte/half extraction.
module tb_asm_stage;
    import core::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    en;
    logic    wb_rdy;
    ex_asm_t ex_asm;
    asm_wb_t asm_wb;
    logic    rdy;
`ifdef ASM_STAGE_FWD_EN
    fwd_t    fwd;
`endif

    asm_stage_if mem_bus ();

    asm_stage dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ex_asm (ex_asm),
        .wb_rdy (wb_rdy),
        .mem    (mem_bus),
        .asm_wb (asm_wb),
        .rdy    (rdy)
`ifdef ASM_STAGE_FWD_EN
        ,
        .fwd    (fwd)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: held result, pending load
    logic        have_out = 1'b0;
    logic        ld_pend = 1'b0;
    asm_wb_t     m_out = '0;
    de_inst_t    ld_inst = '0;
    logic [31:0] ld_addr = '0;
    int          lat = 0;
    logic        armed = 1'b0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [31:0] w,
                                          input logic [1:0] off,
                                          input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            LB:      return b[7] ? (b | 32'hFFFF_FF00) : b;
            LBU:     return b;
            LH:      return h[15] ? (h | 32'hFFFF_0000) : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    task automatic step(input logic r, input logic e, input ex_asm_t x,
                        input logic d, input logic [31:0] dd,
                        input logic w);
        logic exp_rdy;
        logic exp_en;
        rst    = r;
        en     = e;
        ex_asm = x;
        wb_rdy = w;
        mem_bus.mem_read_rsp.done = d;
        mem_bus.mem_read_rsp.data = dd;
        #1;
        exp_rdy = e && !r && !ld_pend && (!have_out || w);
        exp_en  = !r && ld_pend;
        if (armed) begin
            chk("rdy", {31'd0, rdy}, {31'd0, exp_rdy});
            chk("wb_valid", {31'd0, asm_wb.valid}, {31'd0, m_out.valid});
            if (m_out.valid) begin
                chk("wb_inst", {22'd0, asm_wb.de_inst},
                    {22'd0, m_out.de_inst});
                chk("wb_result", asm_wb.asm_result, m_out.asm_result);
            end
            chk("req_en", {31'd0, mem_bus.mem_read_req.en},
                {31'd0, exp_en});
            if (exp_en)
                chk("req_addr", mem_bus.mem_read_req.addr,
                    {ld_addr[31:2], 2'b00});
`ifdef ASM_STAGE_FWD_EN
            chk("fwd_valid", {31'd0, fwd.valid},
                {31'd0, m_out.valid && m_out.de_inst.has_rd
                        && m_out.de_inst.rd != 0});
            if (fwd.valid)
                chk("fwd_data", fwd.data, m_out.asm_result);
`endif
        end
        if (r) begin
            have_out = 1'b0;
            ld_pend  = 1'b0;
            m_out    = '0;
        end else begin
            if (ld_pend && d) begin
                m_out.valid      = 1'b1;
                m_out.de_inst    = ld_inst;
                m_out.asm_result = m_ext(dd, ld_addr[1:0],
                                         ld_inst.funct3);
                have_out = 1'b1;
                ld_pend  = 1'b0;
            end else if (have_out && w) begin
                have_out    = 1'b0;
                m_out.valid = 1'b0;
            end else if (ld_pend && lat > 0) begin
                lat--;
            end
            if (exp_rdy && x.valid) begin
                if (x.de_inst.is_load) begin
                    ld_pend     = 1'b1;
                    ld_inst     = x.de_inst;
                    ld_addr     = x.ex_result;
                    have_out    = 1'b0;
                    m_out.valid = 1'b0;
                    lat         = $urandom_range(0, 3);
                end else begin
                    m_out.valid      = 1'b1;
                    m_out.de_inst    = x.de_inst;
                    m_out.asm_result = x.ex_result;
                    have_out         = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic ex_asm_t mk(input logic v, input logic ld,
                                   input logic [2:0] f3,
                                   input logic [31:0] res);
        ex_asm_t x;
        x = '0;
        x.valid          = v;
        x.de_inst.rd     = 5'd5;
        x.de_inst.has_rd = 1'b1;
        x.de_inst.is_load = ld;
        x.de_inst.funct3 = f3;
        x.ex_result      = res;
        return x;
    endfunction

    task automatic do_load(input string n, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] exp);
        step(0, 1, mk(1, 1, f3, a), 0, 0, 1);
        repeat (3) begin
            chk({n, "_addr"}, mem_bus.mem_read_req.addr, 32'h100);
            step(0, 1, mk(0, 0, 0, 0), 0, 0, 1);
        end
        step(0, 1, mk(0, 0, 0, 0), 1, w, 1);
        chk({n, "_valid"}, {31'd0, asm_wb.valid}, 32'd1);
        chk(n, asm_wb.asm_result, exp);
    endtask

    initial begin
        ex_asm_t x;
        logic    d;
        @(negedge clk);
        step(1, 0, mk(0, 0, 0, 0), 0, 0, 0);
        armed = 1'b1;
        step(1, 0, mk(0, 0, 0, 0), 0, 0, 0);
        chk("rst_valid", {31'd0, asm_wb.valid}, 32'd0);
        chk("rst_result", asm_wb.asm_result, 32'd0);

        // non-load, then back-to-back second instruction
        step(0, 1, mk(1, 0, 3'b000, 32'h1234), 0, 0, 1);
        chk("add_valid", {31'd0, asm_wb.valid}, 32'd1);
        chk("add_result", asm_wb.asm_result, 32'h1234);
        chk("add_rd", {27'd0, asm_wb.de_inst.rd}, 32'd5);
        step(0, 1, mk(1, 0, 3'b000, 32'h4321), 0, 0, 1);
        chk("b2b_result", asm_wb.asm_result, 32'h4321);

        do_load("lb",  LB,  32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu", LBU, 32'h103, 32'h80FF_0000, 32'h0000_0080);
        do_load("lh",  LH,  32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu", LHU, 32'h102, 32'h8001_7FFF, 32'h0000_8001);
        do_load("lw",  LW,  32'h102, 32'h8001_7FFF, 32'h8001_7FFF);

        // backpressure
        step(0, 1, mk(1, 0, 0, 32'hA5A5), 0, 0, 1);
        repeat (4) begin
            step(0, 1, mk(1, 0, 0, 32'h5A5A), 0, 0, 0);
            chk("bp_hold", asm_wb.asm_result, 32'hA5A5);
            chk("bp_rdy", {31'd0, rdy}, 32'd0);
        end
        step(0, 1, mk(1, 0, 0, 32'h5A5A), 0, 0, 1);
        chk("bp_next", asm_wb.asm_result, 32'h5A5A);

        // reset while a load is outstanding
        step(0, 1, mk(1, 1, LW, 32'h200), 0, 0, 1);
        step(0, 1, mk(0, 0, 0, 0), 0, 0, 1);
        step(1, 1, mk(0, 0, 0, 0), 0, 0, 1);
        chk("rstld_valid", {31'd0, asm_wb.valid}, 32'd0);
        step(0, 1, mk(0, 0, 0, 0), 1, 32'hDEAD_BEEF, 1);
        chk("late_done", {31'd0, asm_wb.valid}, 32'd0);
        chk("late_req", {31'd0, mem_bus.mem_read_req.en}, 32'd0);

        // en low with a pending load
        step(0, 1, mk(1, 1, LW, 32'h200), 0, 0, 1);
        step(0, 0, mk(1, 0, 0, 32'h77), 0, 0, 1);
        step(0, 0, mk(1, 0, 0, 32'h77), 1, 32'h1122_3344, 1);
        chk("en0_load", asm_wb.asm_result, 32'h1122_3344);
        step(0, 0, mk(1, 0, 0, 32'h77), 0, 0, 1);
        chk("en0_retire", {31'd0, asm_wb.valid}, 32'd0);
        step(0, 1, mk(1, 0, 0, 32'h77), 0, 0, 1);
        chk("en1_accept", asm_wb.asm_result, 32'h77);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            x = '0;
            x.valid           = ($urandom_range(0, 9) < 7);
            x.de_inst.rd      = 5'($urandom);
            x.de_inst.has_rd  = 1'($urandom);
            x.de_inst.is_load = 1'($urandom);
            x.de_inst.funct3  = 3'($urandom);
            x.ex_result       = $urandom;
            if (ld_pend)
                d = (lat == 0);
            else
                d = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
                 x, d, $urandom, $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asm_stage.md
Name: asm_stage

Overview:
- Assemble stage; sits directly upstream of the writeback stage.
- Takes executed instructions from the execute stage and completes loads through a data-memory read handshake.
- Sign/zero-extends load data and registers the final result into the core::asm_wb_t bundle consumed by writeback.
- Stalls upstream whenever writeback has not yet retired the held result.

Parameters:
- XLEN, 32, datapath width in bits. Only 32 is supported.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1 (bool)  reset; synchronous, active-high.
- en  input  1 (bool)  stage enable. When low, no new instruction is accepted.
- ex_asm  input  core::ex_asm_t  from execute: valid, de_inst (rd, has_rd, is_load, funct3), ex_result (XLEN; ALU result or load address).
- mem_read_rsp  input  core::mem_read_rsp_t  done (1), data (XLEN; aligned word).
- wb_rdy  input  1 (bool)  writeback has retired the current asm_wb this cycle.
- mem_read_req  output  core::mem_read_req_t  en (1), addr (XLEN; word-aligned).
- asm_wb  output  core::asm_wb_t  registered valid, de_inst, asm_result (XLEN).
- rdy  output  1 (bool)  stage accepts ex_asm this cycle.

Behaviour:
- States: IDLE, MEM_WAIT, OUT_HOLD.
- Reset (rst high at edge): state=IDLE, asm_wb.valid=0, asm_wb.asm_result=0, held instruction cleared.
- While rst is high, combinationally: mem_read_req.en=0 and rdy=0.
- Reset mid-load abandons the load. A done arriving afterwards is ignored.
- rdy = en && !rst && (state==IDLE || (state==OUT_HOLD && wb_rdy)).
- Accept = rdy && ex_asm.valid.
- Accept of a non-load:
  - next cycle asm_wb = {valid=1, de_inst, asm_result=ex_result}; state=OUT_HOLD.
  - Latency 1 cycle.
- Accept of a load:
  - Latch de_inst and address; state=MEM_WAIT; asm_wb.valid=0.
  - mem_read_req.en=1 from the next cycle.
  - addr = {latched_addr[XLEN-1:2],2'b00}, held stable until done.
- MEM_WAIT with mem_read_rsp.done=1 at an edge:
  - asm_wb.valid=1, asm_result = extracted data; state=OUT_HOLD.
  - mem_read_req.en drops the cycle after done.
  - Load latency = 1 + memory latency.
- Extraction, off=addr[1:0]:
  - funct3 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend half[off[1]].
  - 101 LHU: zero-extend half[off[1]].
  - 010 LW: full word.
  - Misaligned halfword/word: low offset bits are ignored as above. No fault is raised.
  - Other funct3 values: result = word.
- OUT_HOLD with wb_rdy=1:
  - If accept in the same cycle, the new instruction is processed as from IDLE (back-to-back; no bubble for non-loads).
  - Otherwise asm_wb.valid=0 and state=IDLE.
- OUT_HOLD with wb_rdy=0: asm_wb is held bit-stable; rdy=0.
- en low:
  - No accept.
  - MEM_WAIT continues and completes (an issued request is never dropped).
  - OUT_HOLD still retires on wb_rdy.
- ex_asm.valid=0: no state change from the input side.
- Instructions without rd still flow through to writeback.

Optional Feature:
- Macro: ASM_STAGE_FWD_EN.
- Defined: adds output fwd (core::fwd_t: valid, rd, data).
  - fwd.valid = asm_wb.valid && asm_wb.de_inst.has_rd && rd!=0.
  - fwd.data = asm_wb.asm_result.
  - Used for operand bypass to decode.
- Undefined: port absent and no forwarding logic. Behaviour is otherwise identical.

Decomposition:
- Shared package core: ex_asm_t, asm_wb_t, mem_read_req_t, mem_read_rsp_t, fwd_t, and load funct3 constants (LB, LH, LW, LBU, LHU).
- One sub-module: load_extract (combinational word + offset + funct3 -> XLEN result). Verified standalone.

Test Plan:
- Non-load: ADD result 0x0000_1234, rd=5, wb_rdy=1 -> asm_wb.valid=1, asm_result=0x1234 one cycle after accept; rdy stays 1 for a back-to-back second instruction.
- LB: addr 0x103, memory word 0x80FF_0000, done after 3 cycles -> mem_read_req.addr=0x100 held 3 cycles; asm_result=0xFFFF_FF80. LBU same -> 0x0000_0080.
- LH: addr 0x102, word 0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LW -> 0x8001_7FFF.
- Backpressure: wb_rdy=0 for 4 cycles -> asm_wb stable, rdy=0 for 4 cycles; wb_rdy=1 -> next accepted instruction visible the following cycle.
- Reset in MEM_WAIT -> mem_read_req.en=0 in the rst cycle; asm_wb.valid=0 and state IDLE after the edge; a later done is ignored.
- en=0 with a pending load -> the load completes normally; no new accept until en=1.
